halfband_interp_x2: RTL and testbench
=====================================

// Module: halfband_interp_x2
// PURPOSE
//  15-tap halfband interpolate-by-2 filter; the transmit-side counterpart of the halfband
//  decimator. Sits between the symbol-rate pulse shaper and the DAC-rate datapath.
//  Takes one 1s17 sample per sys_clk2_en and emits two 1s17 samples, one per sam_clk_en.
//  - Phase A: polyphase branch of the even taps, computed with one time-shared multiplier.
//  - Phase B: centre tap. Its coefficient is 0.5, so it is a shift, not a multiply.
// PARAMETERS
//  WIDTH   18  data/coefficient width; data 1s17, coefficients 0s18
//  NTAPS   8   delay-line depth (nonzero branch-A span)
//  ACCW    38  accumulator width (2s34 product + 2 guard bits)
// PORTS
//  sys_clk     in   1      single clock for all logic
//  reset_n     in   1      asynchronous, active-low reset
//  sam_clk_en  in   1      output-rate strobe (2x input rate)
//  sys_clk2_en in   1      input-rate strobe; only asserted together with sam_clk_en, every 2nd
//  x_in        in   18     input sample, 1s17
//  y           out  18     output sample, 1s17, registered
//  y_phase     out  1      0 = y holds phase A, 1 = y holds phase B
//  busy        out  1      MAC sequence in progress
// BEHAVIOUR
//  Reset (async, reset_n=0)
//   - y=0, y_phase=0, busy=0, delay line x[0..7]=0, acc=0, A_reg=B_reg=0, FSM=IDLE.
//   - Takes effect immediately, including mid-MAC. After release, the first sys_clk2_en
//     starts cleanly.
//  Input
//   - On a sys_clk2_en edge: x[0] <= {x_in[17],x_in[17:1]} (2s16), x[k] <= x[k-1].
//  FSM
//   - States: IDLE, PREADD, MAC0..MAC3, DONE. One state per sys_clk.
//   - IDLE -> PREADD on sys_clk2_en (cycle t).
//   - PREADD (t+1): p[k] = x[k] + x[7-k], k=0..3, 18-bit 2s16. The shift prevents overflow.
//   - MACk (t+2..t+5):
//     - product = p[k]*h[k], 36-bit 2s34;
//     - MAC0 loads acc (sign-extended to ACCW); MAC1..3 add to acc.
//   - DONE (t+6):
//     - A_reg = sat18(acc >>> 16): gain x2 folded in, 1s17;
//     - B_reg = x[3] << 1 (centre 0.5 x interp gain 2; exact, no saturation);
//     - -> IDLE.
//   - busy = 1 in PREADD..DONE.
//   - sys_clk2_en while busy: the sample is shifted in, the running sequence aborts and
//     restarts at PREADD. This is a protocol violation; no assertion is required.
//  Coefficients (0s18 constants)
//   - h0=-348, h1=3274, h2=-15925, h3=78535. Centre = 131072 (implicit shift).
//  Saturation (sat18)
//   - Clamp to [-131072, +131071]. No wrap-around is permitted.
//   - Rounding: truncation (floor).
//  Output
//   - Registered on sam_clk_en only; otherwise y and y_phase hold.
//   - sam_clk_en & sys_clk2_en: y <= B_reg, y_phase <= 1. This is window n; B_reg is not yet
//     overwritten.
//   - sam_clk_en & !sys_clk2_en: y <= A_reg, y_phase <= 0.
//   - Output order per input: A_n at the midpoint strobe, then B_n at the next input strobe.
//  Timing requirements
//   - sam_clk_en spacing >= 7 sys_clk, so DONE precedes the midpoint strobe.
//   - Spacing of exactly 7 is legal.
// TESTING
//  1. Impulse: one x_in=+65536, else 0, strobe spacing 8.
//     - Phase-A sequence: -174, 1637, -7963, 39267, 39267, -7963, 1637, -174.
//     - Phase B: a single 65536 aligned to the delay-line centre; 0 elsewhere.
//  2. DC: x_in constant +65536. After 8 inputs, every y = 65536 on both phases (unity gain).
//  3. Saturation: feed 8 inputs so that x[k] = +131071*sign(h_k) over the full window.
//     - Phase A clamps to +131071 (no wrap).
//     - Negated pattern: phase A clamps to -131072.
//  4. Reset mid-MAC: drop reset_n at t+3.
//     - y=0 and busy=0 within the same cycle, asynchronously.
//     - After release, test 1 reproduces exactly.
//  5. Min spacing: sam_clk_en every 7 clocks, random x_in.
//     - Output matches the bit-exact reference model.
//     - y_phase alternates 0,1 with no skips.
//  6. Hold: no strobes for 50 cycles. y, y_phase and busy stay stable.

Source files
------------

// File: rtl/halfband_interp_x2.sv
// 15-tap halfband interpolate-by-2: phase A is a 4-step time-shared MAC over the
// folded even taps, phase B is the 0.5 centre tap realised as a plain shift.
module halfband_interp_x2 #(
    parameter int WIDTH = 18,
    parameter int NTAPS = 8,
    parameter int ACCW  = 38
) (
    input  logic             sys_clk,
    input  logic             reset_n,
    input  logic             sam_clk_en,
    input  logic             sys_clk2_en,
    input  logic [WIDTH-1:0] x_in,
    output logic [WIDTH-1:0] y,
    output logic             y_phase,
    output logic             busy
);

    typedef enum logic [2:0] {IDLE, PREADD, MAC0, MAC1, MAC2, MAC3, DONE} state_t;

    localparam int HALF  = NTAPS / 2;
    localparam int PW    = 2 * WIDTH;
    localparam int SHIFT = WIDTH - 2;

    localparam logic signed [WIDTH-1:0] H0 = -18'sd348;
    localparam logic signed [WIDTH-1:0] H1 = 18'sd3274;
    localparam logic signed [WIDTH-1:0] H2 = -18'sd15925;
    localparam logic signed [WIDTH-1:0] H3 = 18'sd78535;

    localparam logic signed [ACCW-1:0] SAT_MAX = 38'sd131071;
    localparam logic signed [ACCW-1:0] SAT_MIN = -38'sd131072;

    state_t state, next_state;

    logic signed [WIDTH-1:0] x_dl [NTAPS];
    logic signed [WIDTH-1:0] p    [HALF];
    logic signed [ACCW-1:0]  acc;
    logic signed [WIDTH-1:0] a_reg, b_reg;

    logic             mac_load, mac_add, do_preadd, do_done;
    logic [1:0]       coef_sel;
    logic signed [WIDTH-1:0] mult_a, coef;
    logic signed [PW-1:0]    product;
    logic signed [ACCW-1:0]  acc_sh;
    logic signed [WIDTH-1:0] a_sat;

    // x_in is halved on entry, so its LSB never reaches the datapath
    logic unused_lsb;
    assign unused_lsb = x_in[0];

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A new input always (re)starts the sequence, even mid-MAC
    always_comb begin
        next_state = state;
        if (sys_clk2_en) begin
            next_state = PREADD;
        end else begin
            case (state)
                IDLE:    next_state = IDLE;
                PREADD:  next_state = MAC0;
                MAC0:    next_state = MAC1;
                MAC1:    next_state = MAC2;
                MAC2:    next_state = MAC3;
                MAC3:    next_state = DONE;
                DONE:    next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        busy      = (state != IDLE);
        do_preadd = 1'b0;
        mac_load  = 1'b0;
        mac_add   = 1'b0;
        do_done   = 1'b0;
        coef_sel  = 2'd0;
        case (state)
            PREADD: do_preadd = 1'b1;
            MAC0:   mac_load  = 1'b1;
            MAC1:   begin mac_add = 1'b1; coef_sel = 2'd1; end
            MAC2:   begin mac_add = 1'b1; coef_sel = 2'd2; end
            MAC3:   begin mac_add = 1'b1; coef_sel = 2'd3; end
            DONE:   do_done   = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        mult_a = p[coef_sel];
        case (coef_sel)
            2'd0:    coef = H0;
            2'd1:    coef = H1;
            2'd2:    coef = H2;
            default: coef = H3;
        endcase
        product = mult_a * coef;
        acc_sh  = acc >>> SHIFT;
        a_sat   = acc_sh[WIDTH-1:0];
        if (acc_sh > SAT_MAX) begin
            a_sat = SAT_MAX[WIDTH-1:0];
        end else if (acc_sh < SAT_MIN) begin
            a_sat = SAT_MIN[WIDTH-1:0];
        end
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NTAPS; k++) x_dl[k] <= '0;
            for (int k = 0; k < HALF; k++)  p[k]    <= '0;
            acc   <= '0;
            a_reg <= '0;
            b_reg <= '0;
        end else begin
            if (sys_clk2_en) begin
                x_dl[0] <= {x_in[WIDTH-1], x_in[WIDTH-1:1]};
                for (int k = 1; k < NTAPS; k++) x_dl[k] <= x_dl[k-1];
            end
            // Symmetric taps share one product: fold the line before multiplying
            if (do_preadd) begin
                for (int k = 0; k < HALF; k++) p[k] <= x_dl[k] + x_dl[NTAPS-1-k];
            end
            if (mac_load) begin
                acc <= {{(ACCW-PW){product[PW-1]}}, product};
            end else if (mac_add) begin
                acc <= acc + {{(ACCW-PW){product[PW-1]}}, product};
            end
            if (do_done) begin
                a_reg <= a_sat;
                b_reg <= x_dl[HALF-1] <<< 1;
            end
        end
    end

    // b_reg still holds the previous window when the next input strobe arrives
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            y       <= '0;
            y_phase <= 1'b0;
        end else if (sam_clk_en) begin
            if (sys_clk2_en) begin
                y       <= b_reg;
                y_phase <= 1'b1;
            end else begin
                y       <= a_reg;
                y_phase <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_halfband_interp_x2.sv
// Self-checking bench for halfband_interp_x2: directed impulse/DC/saturation/reset/hold
// cases plus random inputs, compared against a direct-form 8-tap arithmetic model.
module tb_halfband_interp_x2;

    logic        sys_clk = 1'b0;
    logic        reset_n;
    logic        sam_clk_en;
    logic        sys_clk2_en;
    logic [17:0] x_in;
    logic [17:0] y;
    logic        y_phase;
    logic        busy;

    int checks = 0;
    int errors = 0;

    int hist [8];
    int prev_b;
    int last_a;
    int obs_a;
    int obs_b;

    localparam int HFULL [8] = '{-348, 3274, -15925, 78535, 78535, -15925, 3274, -348};
    localparam int IMP_A [8] = '{-174, 1637, -7963, 39267, 39267, -7963, 1637, -174};
    localparam int SAT_SIGN [8] = '{-1, 1, -1, 1, 1, -1, 1, -1};

    halfband_interp_x2 dut (
        .sys_clk     (sys_clk),
        .reset_n     (reset_n),
        .sam_clk_en  (sam_clk_en),
        .sys_clk2_en (sys_clk2_en),
        .x_in        (x_in),
        .y           (y),
        .y_phase     (y_phase),
        .busy        (busy)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic signed [63:0] observed,
                               input logic signed [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    function automatic void resetModel();
        for (int j = 0; j < 8; j++) hist[j] = 0;
        prev_b = 0;
        last_a = 0;
    endfunction

    // Interpolated even phase: full 8-tap sum, x2 gain, floor, clamp
    function automatic int modelA();
        longint s = 0;
        for (int j = 0; j < 8; j++) s += longint'(HFULL[j]) * longint'(hist[j] >>> 1);
        s = s >>> 16;
        if (s > 131071)  s = 131071;
        if (s < -131072) s = -131072;
        return int'(s);
    endfunction

    function automatic int modelB();
        return (hist[3] >>> 1) * 2;
    endfunction

    // Entered just after a negedge; one input strobe, then the midpoint strobe
    task automatic applyStimulus(input int v, input int spacing);
        int exp_a, exp_b;
        for (int j = 7; j > 0; j--) hist[j] = hist[j-1];
        hist[0] = v;
        exp_a = modelA();
        exp_b = modelB();
        sam_clk_en  = 1'b1;
        sys_clk2_en = 1'b1;
        x_in        = 18'(v);
        @(posedge sys_clk);
        #1;
        obs_b = int'($signed(y));
        checkOutput("yPhaseB", $signed(y), prev_b);
        checkOutput("phaseB", y_phase, 1);
        checkOutput("busyStart", busy, 1);
        @(negedge sys_clk);
        sam_clk_en  = 1'b0;
        sys_clk2_en = 1'b0;
        repeat (spacing - 1) @(negedge sys_clk);
        sam_clk_en = 1'b1;
        @(posedge sys_clk);
        #1;
        obs_a = int'($signed(y));
        checkOutput("yPhaseA", $signed(y), exp_a);
        checkOutput("phaseA", y_phase, 0);
        checkOutput("busyMid", busy, 0);
        @(negedge sys_clk);
        sam_clk_en = 1'b0;
        repeat (spacing - 1) @(negedge sys_clk);
        prev_b = exp_b;
        last_a = exp_a;
    endtask

    task automatic runImpulse();
        for (int n = 0; n < 12; n++) begin
            applyStimulus((n == 0) ? 65536 : 0, 8);
            if (n < 8) checkOutput("impulseA", obs_a, IMP_A[n]);
            else       checkOutput("impulseA", obs_a, 0);
            if (n >= 1) checkOutput("impulseB", obs_b, (n == 4) ? 65536 : 0);
        end
    endtask

    initial begin
        logic signed [17:0] r;
        reset_n     = 1'b0;
        sam_clk_en  = 1'b0;
        sys_clk2_en = 1'b0;
        x_in        = '0;
        resetModel();
        repeat (3) @(negedge sys_clk);
        checkOutput("resetY", $signed(y), 0);
        checkOutput("resetPhase", y_phase, 0);
        checkOutput("resetBusy", busy, 0);
        reset_n = 1'b1;
        @(negedge sys_clk);

        $display("[TB] impulse");
        runImpulse();

        $display("[TB] dc");
        for (int n = 0; n < 12; n++) begin
            applyStimulus(65536, 8);
            if (n >= 7) checkOutput("dcA", obs_a, 65536);
            if (n >= 8) checkOutput("dcB", obs_b, 65536);
        end

        $display("[TB] saturation");
        for (int j = 0; j < 8; j++) applyStimulus(131071 * SAT_SIGN[j], 8);
        checkOutput("satPos", obs_a, 131071);
        for (int j = 0; j < 8; j++) applyStimulus(-131071 * SAT_SIGN[j], 8);
        checkOutput("satNeg", obs_a, -131072);

        $display("[TB] random min spacing");
        for (int n = 0; n < 24; n++) begin
            r = 18'($urandom);
            applyStimulus(int'(r), 7);
        end
        for (int n = 0; n < 16; n++) begin
            r = 18'($urandom);
            applyStimulus(int'(r), int'($urandom_range(7, 10)));
        end

        $display("[TB] hold");
        for (int n = 0; n < 5; n++) begin
            repeat (10) @(negedge sys_clk);
            checkOutput("holdY", $signed(y), last_a);
            checkOutput("holdPhase", y_phase, 0);
            checkOutput("holdBusy", busy, 0);
        end

        $display("[TB] reset mid-MAC");
        sam_clk_en  = 1'b1;
        sys_clk2_en = 1'b1;
        x_in        = 18'(12345);
        @(posedge sys_clk);
        @(negedge sys_clk);
        sam_clk_en  = 1'b0;
        sys_clk2_en = 1'b0;
        repeat (3) @(posedge sys_clk);
        #2;
        checkOutput("busyMac", busy, 1);
        reset_n = 1'b0;
        #1;
        checkOutput("asyncResetY", $signed(y), 0);
        checkOutput("asyncResetBusy", busy, 0);
        checkOutput("asyncResetPhase", y_phase, 0);
        @(negedge sys_clk);
        reset_n = 1'b1;
        resetModel();
        @(negedge sys_clk);
        runImpulse();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
